// File: rtl/seq_divider.sv
// seq_divider
//   Sequential radix-2 restoring integer divider. This is the responder side of
//   a start/done handshake. A request is accepted on an edge where start=1 and
//   the block is idle. The quotient, remainder and a divide-by-zero flag are
//   returned with a one-cycle done pulse. Each request selects signed
//   (two's-complement) or unsigned operation.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; aborts any division in flight
//   dividendIn    dividend, sampled on the accepting edge
//   divisorIn     divisor, sampled on the accepting edge
//   sign          1 = signed, 0 = unsigned, sampled with the operands
//   start         request strobe, ignored while busy
//   quotientOut   registered quotient, held until the next result
//   remainderOut  registered remainder, held until the next result
//   error         divide-by-zero flag, held until the next result
//   done          one-cycle pulse when results are written
//   busy          high from the accepting edge until the edge that raises done
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividendIn,
  input  logic [WIDTH-1:0] divisorIn,
  input  logic             sign,
  input  logic             start,
  output logic [WIDTH-1:0] quotientOut,
  output logic [WIDTH-1:0] remainderOut,
  output logic             error,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] dividend_reg;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   trial;
  logic             in_zero;

  // Operand magnitudes. The most negative value maps to itself. Read as
  // unsigned, that is exactly its magnitude, so MIN / -1 wraps back to MIN
  // without any special case.
  assign dvd_abs = (sign && dividendIn[WIDTH-1]) ? -dividendIn : dividendIn;
  assign dvs_abs = (sign && divisorIn[WIDTH-1])  ? -divisorIn  : divisorIn;
  assign in_zero = (divisorIn == '0);

  // Trial subtraction on the shifted partial remainder. It is one bit wider
  // than the operands so that the borrow can be seen in the top bit.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, div_mag};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = in_zero ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        if (count == '0) begin
          next_state = FINISH;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quotientOut  <= '0;
      remainderOut <= '0;
      error        <= 1'b0;
      done         <= 1'b0;
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      div_mag      <= '0;
      dividend_reg <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividendIn;
            div_zero     <= in_zero;
            neg_q        <= sign & (dividendIn[WIDTH-1] ^ divisorIn[WIDTH-1]);
            neg_r        <= sign & dividendIn[WIDTH-1];
            rem          <= '0;
            quo          <= dvd_abs;
            div_mag      <= dvs_abs;
            count        <= CW'(WIDTH - 1);
          end
        end
        DIVIDE: begin
          // The partial remainder always stays below div_mag, so a successful
          // trial difference fits back into WIDTH bits.
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          if (div_zero) begin
            quotientOut  <= '1;
            remainderOut <= dividend_reg;
            error        <= 1'b1;
          end else begin
            quotientOut  <= neg_q ? -quo : quo;
            remainderOut <= neg_r ? -rem : rem;
            error        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider at WIDTH=32. Directed requests use
//   hand-computed results and latencies. A reference model built from plain
//   integer arithmetic predicts done, busy and the result registers on every
//   cycle. The bench drives inputs on falling edges and samples outputs on
//   falling edges.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] dividendIn;
  logic [W-1:0] divisorIn;
  logic         sign;
  logic         start;
  logic [W-1:0] quotientOut;
  logic [W-1:0] remainderOut;
  logic         error;
  logic         done;
  logic         busy;

  int tests;
  int failures;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .dividendIn   (dividendIn),
    .divisorIn    (divisorIn),
    .sign         (sign),
    .start        (start),
    .quotientOut  (quotientOut),
    .remainderOut (remainderOut),
    .error        (error),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic. SystemVerilog signed division truncates toward
  // zero, and the remainder follows the dividend's sign, which is the
  // required behaviour. Working in 64 bits lets MIN / -1 come out as +2^31,
  // which truncates to MIN.
  function automatic void modelDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      e = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      e = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      e = 1'b0;
    end
  endfunction

  // Model state: the expected output registers and the pending result.
  int           edge_cnt;
  int           m_done_edge;
  bit           m_valid;
  bit           m_busy;
  logic [W-1:0] p_q, p_r, e_q, e_r;
  logic         p_e, e_e, e_done;

  // Model update. A request accepted at edge N completes at edge N+W+1, or
  // at N+1 when the divisor is zero. While a request is pending, start is
  // ignored.
  initial begin
    edge_cnt = 0;
    m_valid  = 0;
    m_busy   = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        m_valid = 1;
        m_busy  = 0;
        e_q = '0; e_r = '0; e_e = 1'b0; e_done = 1'b0;
      end else begin
        e_done = 1'b0;
        if (m_busy && edge_cnt == m_done_edge) begin
          e_q = p_q; e_r = p_r; e_e = p_e; e_done = 1'b1;
          m_busy = 0;
        end else if (!m_busy && start) begin
          modelDiv(dividendIn, divisorIn, sign, p_q, p_r, p_e);
          m_done_edge = edge_cnt + ((divisorIn == '0) ? 1 : W + 1);
          m_busy = 1;
        end
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("model done", W'(done), W'(e_done));
        checkOutput("model busy", W'(busy), W'(m_busy));
        checkOutput("model quotient", quotientOut, e_q);
        checkOutput("model remainder", remainderOut, e_r);
        checkOutput("model error", W'(error), W'(e_e));
      end
    end
  end

  // Present the operands and hold start for one edge. The task returns on
  // the falling edge just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividendIn = a;
    divisorIn  = b;
    sign       = s;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait, with a bound, for done. lat counts edges after the accepting edge.
  task automatic waitDone(input int from, output int lat);
    lat = from;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic countDones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
    @(negedge clk);
    launch(a, b, s);
    waitDone(0, lat);
  endtask

  task automatic checkResult(input string name, input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
    checkOutput({name, " quotient"}, quotientOut, q);
    checkOutput({name, " remainder"}, remainderOut, r);
    checkOutput({name, " error"}, W'(error), W'(e));
    checkOutput({name, " done"}, W'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [W-1:0] mq, mr;
    logic me;
    tests = 0;
    failures = 0;

    // Pin the reference arithmetic with a few hand-computed cases.
    modelDiv(32'd100, 32'd7, 1'b0, mq, mr, me);
    checkOutput("ref 100/7 q", mq, 32'd14);
    checkOutput("ref 100/7 r", mr, 32'd2);
    modelDiv(32'hFFFFFFF9, 32'd2, 1'b1, mq, mr, me);
    checkOutput("ref -7/2 q", mq, 32'hFFFFFFFD);
    checkOutput("ref -7/2 r", mr, 32'hFFFFFFFF);
    modelDiv(32'h80000000, 32'hFFFFFFFF, 1'b1, mq, mr, me);
    checkOutput("ref MIN/-1 q", mq, 32'h80000000);

    reset = 1'b1; start = 1'b0; dividendIn = '0; divisorIn = '0; sign = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", W'(busy), 32'd0);
    checkOutput("reset done", W'(done), 32'd0);
    checkOutput("reset quotient", quotientOut, 32'd0);
    checkOutput("reset remainder", remainderOut, 32'd0);
    checkOutput("reset error", W'(error), 32'd0);
    reset = 1'b0;

    applyStimulus(32'd100, 32'd7, 1'b0, lat);
    checkOutput("100/7 latency", lat, 32'd33);
    checkResult("100/7", 32'd14, 32'd2, 1'b0);

    applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1, lat);
    checkResult("-7/2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);

    applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, lat);
    checkResult("7/-2", 32'hFFFFFFFD, 32'd1, 1'b0);

    applyStimulus(32'd5, 32'd0, 1'b0, lat);
    checkOutput("5/0u latency", lat, 32'd1);
    checkResult("5/0u", 32'hFFFFFFFF, 32'd5, 1'b1);

    applyStimulus(32'd5, 32'd0, 1'b1, lat);
    checkOutput("5/0s latency", lat, 32'd1);
    checkResult("5/0s", 32'hFFFFFFFF, 32'd5, 1'b1);

    applyStimulus(32'd9, 32'd3, 1'b0, lat);
    checkResult("9/3", 32'd3, 32'd0, 1'b0);

    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
    checkResult("MIN/-1", 32'h80000000, 32'd0, 1'b0);

    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, lat);
    checkResult("FFFFFFFF/1", 32'hFFFFFFFF, 32'd0, 1'b0);

    applyStimulus(32'd3, 32'h80000000, 1'b0, lat);
    checkResult("3/80000000", 32'd0, 32'd3, 1'b0);

    // A start pulse in the middle of a division must be ignored.
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    launch(32'd50, 32'd5, 1'b0);
    waitDone(10, lat);
    checkOutput("mid-start latency", lat, 32'd33);
    checkResult("mid-start", 32'd14, 32'd2, 1'b0);

    // Back-to-back: start is raised during the done cycle.
    launch(32'd200, 32'd9, 1'b0);
    waitDone(0, lat);
    checkOutput("back-to-back latency", lat, 32'd33);
    checkResult("200/9", 32'd22, 32'd2, 1'b0);
    countDones(40, cnt);
    checkOutput("single done count", cnt, 32'd0);

    // Reset on the tenth edge of a division aborts it.
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", W'(busy), 32'd0);
    checkOutput("abort done", W'(done), 32'd0);
    checkOutput("abort quotient", quotientOut, 32'd0);
    checkOutput("abort remainder", remainderOut, 32'd0);
    checkOutput("abort error", W'(error), 32'd0);
    reset = 1'b0;
    countDones(40, cnt);
    checkOutput("abort no done", cnt, 32'd0);

    applyStimulus(32'd100, 32'd7, 1'b0, lat);
    checkOutput("post-abort latency", lat, 32'd33);
    checkResult("post-abort 100/7", 32'd14, 32'd2, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
